// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one CPU-side request at a time. Reads are
// IDLE -> ACCESS -> IDLE. Writes are IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
// Every SRAM-facing output is registered, so strobes change only on Clk edges
// or on reset.
module sram_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we_req,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  CE,
  output logic                  OE,
  output logic                  WE,
  output logic [DATA_W/8-1:0]   BE_N,
  output logic [ADDR_W-1:0]     ADDR,
  inout  wire  [DATA_W-1:0]     Data
);

  localparam int          BE_W    = DATA_W / 8;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t              state, state_next;
  logic [3:0]          wait_cnt, wait_cnt_next;
  logic                accept;
  logic                read_done;
  logic                is_write;
  logic                bus_en;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                data_oe;

  // Values the transaction will use next cycle: taken from the inputs on
  // the accept edge, otherwise from the latched copies.
  logic                op_write_next;
  logic                bus_en_next;
  logic [BE_W-1:0]     be_sel;

  logic                ready_next, ce_next, oe_next, we_next, data_oe_next;
  logic [BE_W-1:0]     be_n_next;

  // The data bus is driven only while a write owns it.
  assign Data = data_oe ? wdata_q : {DATA_W{1'bz}};

  // Next-state and wait-counter logic.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    accept        = 1'b0;
    read_done     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept        = 1'b1;
          state_next    = we_req ? SETUP : ACCESS;
          wait_cnt_next = WAIT_LD;
        end else begin
          state_next    = IDLE;
        end
      end
      SETUP: begin
        state_next    = ACCESS;
        wait_cnt_next = WAIT_LD;
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          state_next = is_write ? HOLD : IDLE;
          read_done  = ~is_write;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // Strobe values for the state being entered; registered below.
  always_comb begin
    op_write_next = accept ? we_req : is_write;
    bus_en_next   = accept ? (|be) : bus_en;
    be_sel        = accept ? be : be_q;
    ready_next    = (state_next == IDLE);
    ce_next       = 1'b1;
    oe_next       = 1'b1;
    we_next       = 1'b1;
    data_oe_next  = 1'b0;
    be_n_next     = {BE_W{1'b1}};
    case (state_next)
      IDLE: begin
        ce_next = 1'b1;
      end
      SETUP: begin
        ce_next      = ~bus_en_next;
        be_n_next    = ~be_sel;
        data_oe_next = 1'b1;
      end
      ACCESS: begin
        if (op_write_next) begin
          ce_next      = ~bus_en_next;
          we_next      = ~bus_en_next;
          be_n_next    = ~be_sel;
          data_oe_next = 1'b1;
        end else begin
          ce_next   = 1'b0;
          oe_next   = 1'b0;
          be_n_next = {BE_W{1'b0}};
        end
      end
      HOLD: begin
        ce_next      = ~bus_en_next;
        be_n_next    = ~be_sel;
        data_oe_next = 1'b1;
      end
      default: begin
        ce_next = 1'b1;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Request latches, SRAM address and read-data capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_write <= 1'b0;
      bus_en   <= 1'b0;
      be_q     <= {BE_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      ADDR     <= {ADDR_W{1'b0}};
      rdata    <= {DATA_W{1'b0}};
      rvalid   <= 1'b0;
    end else begin
      if (accept) begin
        is_write <= we_req;
        bus_en   <= |be;
        be_q     <= be;
        wdata_q  <= wdata;
        ADDR     <= addr;
      end
      if (read_done) begin
        rdata <= Data;
      end
      rvalid <= read_done;
    end
  end

  // Registered strobes, byte lanes, bus enable and ready.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ready   <= 1'b1;
      CE      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      BE_N    <= {BE_W{1'b1}};
      data_oe <= 1'b0;
    end else begin
      ready   <= ready_next;
      CE      <= ce_next;
      OE      <= oe_next;
      WE      <= we_next;
      BE_N    <= be_n_next;
      data_oe <= data_oe_next;
    end
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SRAM data width; multiple of 8, range 8..32.
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter WAIT_CYCLES, default 1, extra access-phase cycles, range 0..15.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  reset, asynchronous and active-high.
REQ-006 req  input  1  transaction request from the CPU side.
REQ-007 we_req  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  word address; sampled on accept.
REQ-009 wdata  input  DATA_W  write data; sampled on accept.
REQ-010 be  input  DATA_W/8  write byte enables, bit i = byte i; sampled on accept.
REQ-011 ready  output  1  high only in IDLE; request accepted on an edge where req && ready.
REQ-012 rdata  output  DATA_W  last read data; holds until the next read completes.
REQ-013 rvalid  output  1  one-cycle pulse when rdata updates.
REQ-014 CE, OE, WE  output  1 each  active-low SRAM strobes.
REQ-015 BE_N  output  DATA_W/8  active-low byte lanes; for DATA_W=16, bit1 = UB and bit0 = LB.
REQ-016 ADDR  output  ADDR_W  registered SRAM address.
REQ-017 Data  inout  DATA_W  SRAM data bus; driven only by the write states, else high-Z.

Function
REQ-018 The FSM SHALL use the states IDLE, SETUP, ACCESS and HOLD, with a 4-bit wait counter.
REQ-019 In IDLE, all strobes high, BE_N all ones, Data high-Z, ready=1.
REQ-020 An accepted read goes IDLE->ACCESS with CE=0, OE=0, BE_N all zero and ADDR latched, holding for WAIT_CYCLES+1 cycles.
REQ-021 On the last read ACCESS edge, Data is captured into rdata, the FSM returns to IDLE and rvalid=1 for that one IDLE cycle; accept-to-rvalid = WAIT_CYCLES+1 cycles.
REQ-022 An accepted write goes IDLE->SETUP for 1 cycle: CE=0, WE=1, OE=1, BE_N=~be, ADDR and Data driven from latched values.
REQ-023 Write SETUP->ACCESS: WE=0 for WAIT_CYCLES+1 cycles, with all other outputs unchanged.
REQ-024 Write ACCESS->HOLD for 1 cycle: WE=1, CE=0, Data still driven; then HOLD->IDLE; a write is busy for WAIT_CYCLES+3 cycles.
REQ-025 A write with be==0 SHALL follow the same timing with CE=1 and WE=1 throughout (no bus cycle).
REQ-026 OE=0 and a driven Data bus SHALL never coexist in any cycle.
REQ-027 req while ready=0 is ignored, not queued; addr, wdata and be changes after accept have no effect.
REQ-028 Back-to-back requests SHALL be accepted in the IDLE cycle immediately following the previous completion, including the rvalid cycle.
REQ-029 ADDR holds its last value in IDLE; rdata does not change on writes.

Reset
REQ-030 Reset asserted SHALL immediately (asynchronously) force IDLE, CE=OE=WE=1, BE_N all ones, Data high-Z, rvalid=0, rdata=0, ADDR=0 and wait counter=0.
REQ-031 Reset mid-transaction aborts it; a write is not completed, rvalid does not pulse, and the first request after release is accepted normally.

Verification (WAIT_CYCLES=1, DATA_W=16)
REQ-032 Read: SRAM word 0x00010 = 0xBEEF, req/we_req=0/addr=0x00010 -> CE/OE low 2 cycles, rvalid pulse 2 cycles after accept, rdata=0xBEEF.
REQ-033 Write: addr=0x00020, wdata=0x1234, be=2'b11 -> SETUP 1, WE low 2, HOLD 1, ready after 4 cycles; readback returns 0x1234.
REQ-034 Byte write: be=2'b10, wdata=0xAB00 onto word 0x1234 -> UB=0, LB=1; readback returns 0xAB34.
REQ-035 Busy ignore: second req asserted during a write ACCESS -> no second accept until IDLE; exactly one transaction per accept edge.
REQ-036 Reset mid-write in ACCESS -> WE=1 and Data high-Z in the same cycle, memory unchanged, ready=1 after release.
REQ-037 Bus contention check over all tests -> Data never driven while OE=0; be==0 write produces no CE pulse.
